apb_master_bridge: RTL and testbench

- Single-outstanding APB initiator that converts a simple CPU-side load/store request into an APB SETUP/ACCESS transfer.
- Drives the CPU-side master port of the APB slave mux (apb_*_cpu signals) and waits for the returned ack.
- Returns read data or write completion to the CPU, with a wait-state timeout so a hung slave cannot stall the core.

---
 rtl/apb_master_bridge_pkg.sv | 13 +
 rtl/apb_master_bridge.sv | 119 +++++++++++
 tb/tb_apb_master_bridge.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_master_bridge_pkg.sv
// Shared APB bridge definitions: bus widths and FSM state encoding.
package apb_master_bridge_pkg;

    localparam int ADDR_APB = 32;
    localparam int DATA_APB = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

endpackage

// File: rtl/apb_master_bridge.sv
// Single-outstanding APB initiator: CPU load/store to APB SETUP/ACCESS,
// with a wait-state timeout so a hung slave cannot stall the core.
module apb_master_bridge
    import apb_master_bridge_pkg::*;
#(
    parameter int ADDR_W  = ADDR_APB,
    parameter int DATA_W  = DATA_APB,
    parameter int TIMEOUT = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_wr,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_resp_valid,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_err,
    output logic              apb_valid_cpu,
    output logic              apb_psel_cpu,
    output logic              apb_rw_cpu,
    output logic [ADDR_W-1:0] apb_addr_cpu,
    output logic              apb_enab_cpu,
    output logic [DATA_W-1:0] apb_datai_cpu,
    input  logic [DATA_W-1:0] apb_datao_cpu,
    input  logic              apb_ack_cpu
);

    // A zero TIMEOUT still needs a legal one-bit counter.
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] wait_cnt;
    logic             load;
    logic             ack_done;
    logic             to_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next    = state;
        load          = 1'b0;
        ack_done      = 1'b0;
        to_done       = 1'b0;
        cpu_gnt       = 1'b0;
        apb_psel_cpu  = 1'b0;
        apb_enab_cpu  = 1'b0;
        apb_valid_cpu = 1'b0;
        unique case (state)
            IDLE: begin
                cpu_gnt = 1'b1;
                if (cpu_req) begin
                    load       = 1'b1;
                    state_next = SETUP;
                end
            end
            SETUP: begin
                apb_psel_cpu  = 1'b1;
                apb_valid_cpu = 1'b1;
                state_next    = ACCESS;
            end
            ACCESS: begin
                apb_psel_cpu  = 1'b1;
                apb_enab_cpu  = 1'b1;
                apb_valid_cpu = 1'b1;
                if (apb_ack_cpu) begin
                    ack_done   = 1'b1;
                    state_next = IDLE;
                end else if (TIMEOUT != 0 && wait_cnt == CNT_LAST) begin
                    to_done    = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            apb_rw_cpu     <= 1'b0;
            apb_addr_cpu   <= '0;
            apb_datai_cpu  <= '0;
            wait_cnt       <= '0;
            cpu_resp_valid <= 1'b0;
            cpu_rdata      <= '0;
            cpu_err        <= 1'b0;
        end else begin
            cpu_resp_valid <= ack_done | to_done;
            if (load) begin
                apb_rw_cpu    <= cpu_wr;
                apb_addr_cpu  <= cpu_addr;
                apb_datai_cpu <= cpu_wdata;
                wait_cnt      <= '0;
            end else if (state == ACCESS && !ack_done && !to_done) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (ack_done) begin
                cpu_rdata <= apb_rw_cpu ? '0 : apb_datao_cpu;
                cpu_err   <= 1'b0;
            end else if (to_done) begin
                cpu_rdata <= '0;
                cpu_err   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Self-checking bench for apb_master_bridge with a cycle-level slave model.
module tb_apb_master_bridge;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_req = 1'b0;
    logic        cpu_wr = 1'b0;
    logic [31:0] cpu_addr = '0;
    logic [31:0] cpu_wdata = '0;
    logic        cpu_gnt;
    logic        cpu_resp_valid;
    logic [31:0] cpu_rdata;
    logic        cpu_err;
    logic        apb_valid_cpu;
    logic        apb_psel_cpu;
    logic        apb_rw_cpu;
    logic [31:0] apb_addr_cpu;
    logic        apb_enab_cpu;
    logic [31:0] apb_datai_cpu;
    logic [31:0] apb_datao_cpu = '0;
    logic        apb_ack_cpu = 1'b0;

    int          checks = 0;
    int          errors = 0;
    logic        pend = 1'b0;
    logic        pend_err = 1'b0;
    logic [31:0] pend_rdata = '0;
    logic        last_err = 1'b0;
    logic [31:0] last_rdata = '0;

    apb_master_bridge #(
        .ADDR_W (32),
        .DATA_W (32),
        .TIMEOUT(TO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cpu_req       (cpu_req),
        .cpu_wr        (cpu_wr),
        .cpu_addr      (cpu_addr),
        .cpu_wdata     (cpu_wdata),
        .cpu_gnt       (cpu_gnt),
        .cpu_resp_valid(cpu_resp_valid),
        .cpu_rdata     (cpu_rdata),
        .cpu_err       (cpu_err),
        .apb_valid_cpu (apb_valid_cpu),
        .apb_psel_cpu  (apb_psel_cpu),
        .apb_rw_cpu    (apb_rw_cpu),
        .apb_addr_cpu  (apb_addr_cpu),
        .apb_enab_cpu  (apb_enab_cpu),
        .apb_datai_cpu (apb_datai_cpu),
        .apb_datao_cpu (apb_datao_cpu),
        .apb_ack_cpu   (apb_ack_cpu)
    );

    always #5 clk = ~clk;

    // Idle cycles: acks from the slave side must be ignored here.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            cpu_req       = 1'b0;
            apb_ack_cpu   = 1'($urandom);
            apb_datao_cpu = $urandom;
            @(negedge clk);
            checks++;
            if (pend) begin
                if (cpu_resp_valid !== 1'b1 || cpu_err !== pend_err ||
                    cpu_rdata !== pend_rdata) begin
                    errors++;
                    $display("FAIL idle_resp: v=%b err=%b rdata=%h want 1 %b %h",
                             cpu_resp_valid, cpu_err, cpu_rdata,
                             pend_err, pend_rdata);
                end
                last_err   = pend_err;
                last_rdata = pend_rdata;
                pend       = 1'b0;
            end else if (cpu_resp_valid !== 1'b0 || cpu_err !== last_err ||
                         cpu_rdata !== last_rdata) begin
                errors++;
                $display("FAIL idle_hold: v=%b err=%b rdata=%h want 0 %b %h",
                         cpu_resp_valid, cpu_err, cpu_rdata,
                         last_err, last_rdata);
            end
            checks++;
            if (cpu_gnt !== 1'b1 || apb_psel_cpu !== 1'b0 ||
                apb_enab_cpu !== 1'b0 || apb_valid_cpu !== 1'b0) begin
                errors++;
                $display("FAIL idle_bus: gnt=%b psel=%b enab=%b valid=%b want 1000",
                         cpu_gnt, apb_psel_cpu, apb_enab_cpu, apb_valid_cpu);
            end
            @(posedge clk);
            #1;
        end
    endtask

    // One transfer; the slave acks after 'delay' wait states, or never
    // when delay >= TO. Leaves the expected completion pending.
    task automatic xfer(input logic wr, input logic [31:0] a,
                        input logic [31:0] wd, input int delay,
                        input logic [31:0] datao);
        int   acc;
        logic hit;
        hit = (delay < TO);
        acc = hit ? delay + 1 : TO;
        cpu_req       = 1'b1;
        cpu_wr        = wr;
        cpu_addr      = a;
        cpu_wdata     = wd;
        apb_ack_cpu   = 1'($urandom);
        apb_datao_cpu = $urandom;
        @(negedge clk);
        checks++;
        if (pend) begin
            if (cpu_resp_valid !== 1'b1 || cpu_err !== pend_err ||
                cpu_rdata !== pend_rdata) begin
                errors++;
                $display("FAIL resp: v=%b err=%b rdata=%h want 1 %b %h",
                         cpu_resp_valid, cpu_err, cpu_rdata,
                         pend_err, pend_rdata);
            end
            last_err   = pend_err;
            last_rdata = pend_rdata;
            pend       = 1'b0;
        end else if (cpu_resp_valid !== 1'b0 || cpu_err !== last_err ||
                     cpu_rdata !== last_rdata) begin
            errors++;
            $display("FAIL hold: v=%b err=%b rdata=%h want 0 %b %h",
                     cpu_resp_valid, cpu_err, cpu_rdata,
                     last_err, last_rdata);
        end
        checks++;
        if (cpu_gnt !== 1'b1 || apb_psel_cpu !== 1'b0) begin
            errors++;
            $display("FAIL grant: gnt=%b psel=%b want 1 0",
                     cpu_gnt, apb_psel_cpu);
        end
        @(posedge clk);
        #1;
        cpu_req       = 1'b0;
        cpu_wr        = 1'($urandom);
        cpu_addr      = $urandom;
        cpu_wdata     = $urandom;
        apb_ack_cpu   = 1'($urandom);
        @(negedge clk);
        checks++;
        if ({apb_valid_cpu, apb_psel_cpu, apb_enab_cpu,
             cpu_gnt, cpu_resp_valid} !== 5'b11000) begin
            errors++;
            $display("FAIL setup: valid/psel/enab/gnt/resp=%b want 11000",
                     {apb_valid_cpu, apb_psel_cpu, apb_enab_cpu,
                      cpu_gnt, cpu_resp_valid});
        end
        checks++;
        if (apb_rw_cpu !== wr || apb_addr_cpu !== a ||
            apb_datai_cpu !== wd) begin
            errors++;
            $display("FAIL setup_bus: rw=%b addr=%h data=%h want %b %h %h",
                     apb_rw_cpu, apb_addr_cpu, apb_datai_cpu, wr, a, wd);
        end
        for (int k = 0; k < acc; k++) begin
            @(posedge clk);
            #1;
            apb_ack_cpu   = hit && (k == delay);
            apb_datao_cpu = (hit && k == delay) ? datao : $urandom;
            @(negedge clk);
            checks++;
            if ({apb_valid_cpu, apb_psel_cpu, apb_enab_cpu,
                 cpu_gnt, cpu_resp_valid} !== 5'b11100) begin
                errors++;
                $display("FAIL access%0d: valid/psel/enab/gnt/resp=%b want 11100",
                         k, {apb_valid_cpu, apb_psel_cpu, apb_enab_cpu,
                             cpu_gnt, cpu_resp_valid});
            end
            checks++;
            if (apb_rw_cpu !== wr || apb_addr_cpu !== a ||
                apb_datai_cpu !== wd) begin
                errors++;
                $display("FAIL access_bus%0d: rw=%b addr=%h data=%h want %b %h %h",
                         k, apb_rw_cpu, apb_addr_cpu, apb_datai_cpu,
                         wr, a, wd);
            end
        end
        @(posedge clk);
        #1;
        apb_ack_cpu = 1'b0;
        pend        = 1'b1;
        pend_err    = !hit;
        pend_rdata  = (hit && !wr) ? datao : 32'h0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (apb_psel_cpu !== 1'b0 || apb_enab_cpu !== 1'b0 ||
            apb_valid_cpu !== 1'b0 || apb_rw_cpu !== 1'b0 ||
            apb_addr_cpu !== 32'h0 || apb_datai_cpu !== 32'h0 ||
            cpu_rdata !== 32'h0 || cpu_err !== 1'b0 ||
            cpu_resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset: psel=%b enab=%b valid=%b rw=%b addr=%h datai=%h rdata=%h err=%b v=%b want all 0",
                     apb_psel_cpu, apb_enab_cpu, apb_valid_cpu, apb_rw_cpu,
                     apb_addr_cpu, apb_datai_cpu, cpu_rdata, cpu_err,
                     cpu_resp_valid);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(1);
    endtask

    task automatic test_write();
        xfer(1'b1, 32'hBF00_1000, 32'hDEAD_BEEF, 0, 32'hA5A5_A5A5);
        idle(2);
    endtask

    task automatic test_read_wait();
        xfer(1'b0, 32'hBF00_2004, 32'h0, 3, 32'h1234_5678);
        idle(1);
    endtask

    task automatic test_unmapped();
        xfer(1'b0, 32'hDEAD_0000, 32'h0, 0, 32'h0);
        idle(1);
    endtask

    task automatic test_timeout();
        xfer(1'b0, 32'hBF00_3000, 32'h0, 40, 32'h0);
        xfer(1'b0, 32'hBF00_3004, 32'h0, 1, 32'hCAFE_F00D);
        idle(1);
    endtask

    task automatic test_back_to_back();
        xfer(1'b0, 32'hBF00_0010, 32'h0, 0, 32'h1111_1111);
        xfer(1'b0, 32'hBF00_0014, 32'h0, 0, 32'h2222_2222);
        xfer(1'b0, 32'hBF00_0018, 32'h0, 0, 32'h3333_3333);
        idle(1);
    endtask

    task automatic test_reset_abort();
        cpu_req   = 1'b1;
        cpu_wr    = 1'b1;
        cpu_addr  = 32'hBF00_4000;
        cpu_wdata = 32'h5555_AAAA;
        @(posedge clk);
        #1;
        cpu_req     = 1'b0;
        apb_ack_cpu = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (apb_enab_cpu !== 1'b1) begin
            errors++;
            $display("FAIL abort_pre: enab=%b want 1", apb_enab_cpu);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (apb_psel_cpu !== 1'b0 || apb_enab_cpu !== 1'b0 ||
            apb_valid_cpu !== 1'b0 || apb_addr_cpu !== 32'h0) begin
            errors++;
            $display("FAIL abort_async: psel=%b enab=%b valid=%b addr=%h want 0",
                     apb_psel_cpu, apb_enab_cpu, apb_valid_cpu, apb_addr_cpu);
        end
        @(posedge clk);
        #1;
        rst        = 1'b0;
        pend       = 1'b0;
        last_err   = 1'b0;
        last_rdata = 32'h0;
        idle(3);
    endtask

    task automatic test_random();
        for (int n = 0; n < 30; n++) begin
            int r;
            int d;
            r = $urandom_range(0, 9);
            d = (r < 8) ? r % 5 : TO + r;
            xfer(1'($urandom), $urandom, $urandom, d, $urandom);
            idle($urandom_range(0, 2));
        end
        idle(1);
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_wait();
        test_unmapped();
        test_timeout();
        test_back_to_back();
        idle(1);
        test_reset_abort();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
